move_queue_dispatcher: RTL and testbench



---
 rtl/rbot_pkg.sv | 42 ++++
 rtl/move_fifo.sv | 59 +++++
 rtl/move_queue_dispatcher.sv | 200 ++++++++++++++++++++
 tb/tb_move_queue_dispatcher.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbot_pkg.sv
// Move codes, colour codes and FSM state types shared by the solver, update_state
// and the move dispatch path.
package rbot_pkg;

    localparam logic [3:0] MOVE_NOP = 4'd0;
    localparam logic [3:0] MOVE_R   = 4'd2;
    localparam logic [3:0] MOVE_RI  = 4'd3;
    localparam logic [3:0] MOVE_U   = 4'd4;
    localparam logic [3:0] MOVE_UI  = 4'd5;
    localparam logic [3:0] MOVE_F   = 4'd6;
    localparam logic [3:0] MOVE_FI  = 4'd7;
    localparam logic [3:0] MOVE_L   = 4'd8;
    localparam logic [3:0] MOVE_LI  = 4'd9;
    localparam logic [3:0] MOVE_B   = 4'd10;
    localparam logic [3:0] MOVE_BI  = 4'd11;
    localparam logic [3:0] MOVE_D   = 4'd12;
    localparam logic [3:0] MOVE_DI  = 4'd13;

    localparam logic [2:0] COLOR_WHITE  = 3'd0;
    localparam logic [2:0] COLOR_YELLOW = 3'd1;
    localparam logic [2:0] COLOR_RED    = 3'd2;
    localparam logic [2:0] COLOR_ORANGE = 3'd3;
    localparam logic [2:0] COLOR_BLUE   = 3'd4;
    localparam logic [2:0] COLOR_GREEN  = 3'd5;

    typedef enum logic {
        SC_IDLE,
        SC_SCAN
    } sc_state_e;

    typedef enum logic [1:0] {
        D_WAIT,
        D_BUSY,
        D_GAP
    } d_state_e;

    // Codes 0, 1, 14 and 15 are padding / NOP and never reach the stepper.
    function automatic logic move_is_valid(input logic [31:0] code);
        return (code >= 32'(MOVE_R)) && (code <= 32'(MOVE_DI));
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Synchronous move FIFO; head word is registered on pop (one cycle read latency).
// A write while full is taken only when a pop frees a slot in the same cycle.
module move_fifo #(
    parameter int DEPTH  = 256,
    parameter int MOVE_W = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock_25mhz,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [MOVE_W-1:0] wr_dat_i,
    input  logic              rd_en_i,
    output logic [MOVE_W-1:0] rd_dat_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [MOVE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [MOVE_W-1:0] rd_dat_q;
    logic              do_wr;
    logic              do_rd;

    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign do_rd    = rd_en_i && !empty_o;
    assign do_wr    = wr_en_i && (!full_o || do_rd);
    assign rd_dat_o = rd_dat_q;
    assign count_o  = count_q;

    always_ff @(posedge clock_25mhz) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rd_dat_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                rd_dat_q <= mem_q[rd_ptr_q];
            end
            count_q <= count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

endmodule

// File: rtl/move_queue_dispatcher.sv
// Unpacks move chunks (one slot per cycle) into a FIFO and issues them to the stepper
// one at a time with a start/done handshake; chunk_ready is low while a chunk is scanned.
module move_queue_dispatcher
    import rbot_pkg::*;
#(
    parameter int MOVE_W      = 4,
    parameter int CHUNK_MOVES = 50,
    parameter int DEPTH       = 256,
    parameter int GAP_CYCLES  = 0,
    parameter int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                          clock_25mhz,
    input  logic                          reset,
    input  logic [MOVE_W*CHUNK_MOVES-1:0] chunk_in,
    input  logic                          chunk_valid,
    output logic                          chunk_ready,
    input  logic                          plan_done,
    output logic [MOVE_W-1:0]             next_move,
    output logic                          move_start,
    input  logic                          move_done,
    output logic [CNT_W-1:0]              num_moves,
    output logic [CNT_W-1:0]              curr_step,
    output logic                          busy,
    output logic                          overflow,
    output logic                          exec_done
);
    localparam int CHUNK_W = MOVE_W * CHUNK_MOVES;
    localparam int SLOT_W  = (CHUNK_MOVES > 1) ? $clog2(CHUNK_MOVES) : 1;
    localparam int GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    sc_state_e          sc_q, sc_d;
    logic [CHUNK_W-1:0] chunk_q, chunk_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    d_state_e           d_q, d_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic               plan_done_q;
    logic               plan_latched_q;
    logic               move_start_q;
    logic [CNT_W-1:0]   num_moves_q;
    logic [CNT_W-1:0]   curr_step_q;
    logic               overflow_q;
    logic               exec_done_q;

    logic               accept;
    logic [MOVE_W-1:0]  head_code;
    logic               scan_vld;
    logic               wr_ok;
    logic               drop;
    logic               step_done;
    logic               fifo_rd;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    // ---------------- scanner ----------------
    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            sc_q    <= SC_IDLE;
            chunk_q <= '0;
            slot_q  <= '0;
        end else begin
            sc_q    <= sc_d;
            chunk_q <= chunk_d;
            slot_q  <= slot_d;
        end
    end

    // The chunk shifts up one slot per cycle so the slot under test is always the top one.
    always_comb begin
        sc_d    = sc_q;
        chunk_d = chunk_q;
        slot_d  = slot_q;
        case (sc_q)
            SC_IDLE: begin
                if (accept) begin
                    sc_d    = SC_SCAN;
                    chunk_d = chunk_in;
                    slot_d  = SLOT_W'(CHUNK_MOVES - 1);
                end
            end
            SC_SCAN: begin
                chunk_d = chunk_q << MOVE_W;
                slot_d  = slot_q - SLOT_W'(1);
                if (slot_q == '0) begin
                    sc_d = SC_IDLE;
                end
            end
            default: sc_d = SC_IDLE;
        endcase
    end

    always_comb begin
        chunk_ready = (sc_q == SC_IDLE) && !plan_latched_q && !reset;
        head_code   = chunk_q[CHUNK_W-1 -: MOVE_W];
        scan_vld    = (sc_q == SC_SCAN) && move_is_valid(32'(head_code));
    end

    assign accept = chunk_valid && chunk_ready;
    assign wr_ok  = scan_vld && (!fifo_full || fifo_rd);
    assign drop   = scan_vld && fifo_full && !fifo_rd;

    // ---------------- dispatcher ----------------
    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            d_q   <= D_WAIT;
            gap_q <= '0;
        end else begin
            d_q   <= d_d;
            gap_q <= gap_d;
        end
    end

    always_comb begin
        d_d   = d_q;
        gap_d = gap_q;
        case (d_q)
            D_WAIT: begin
                if (fifo_rd) begin
                    d_d = D_BUSY;
                end
            end
            D_BUSY: begin
                if (move_done) begin
                    if (GAP_CYCLES == 0) begin
                        d_d = D_WAIT;
                    end else begin
                        d_d   = D_GAP;
                        gap_d = GAP_W'(GAP_CYCLES);
                    end
                end
            end
            D_GAP: begin
                gap_d = gap_q - GAP_W'(1);
                if (gap_q <= GAP_W'(1)) begin
                    d_d = D_WAIT;
                end
            end
            default: d_d = D_WAIT;
        endcase
    end

    always_comb begin
        fifo_rd   = (d_q == D_WAIT) && plan_latched_q && !fifo_empty;
        busy      = (d_q == D_BUSY);
        step_done = busy && move_done;
    end

    // ---------------- status ----------------
    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            plan_done_q    <= 1'b0;
            plan_latched_q <= 1'b0;
            move_start_q   <= 1'b0;
            num_moves_q    <= '0;
            curr_step_q    <= '0;
            overflow_q     <= 1'b0;
            exec_done_q    <= 1'b0;
        end else begin
            plan_done_q    <= plan_done;
            plan_latched_q <= plan_latched_q | plan_done_q;
            move_start_q   <= fifo_rd;
            if (wr_ok) begin
                num_moves_q <= num_moves_q + CNT_W'(1);
            end
            if (step_done) begin
                curr_step_q <= curr_step_q + CNT_W'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if ((d_q == D_WAIT) && plan_latched_q && (sc_q == SC_IDLE) && (fifo_count == '0)) begin
                exec_done_q <= 1'b1;
            end
        end
    end

    assign move_start = move_start_q;
    assign num_moves  = num_moves_q;
    assign curr_step  = curr_step_q;
    assign overflow   = overflow_q;
    assign exec_done  = exec_done_q;

    move_fifo #(
        .DEPTH  (DEPTH),
        .MOVE_W (MOVE_W),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clock_25mhz (clock_25mhz),
        .reset       (reset),
        .wr_en_i     (scan_vld),
        .wr_dat_i    (head_code),
        .rd_en_i     (fifo_rd),
        .rd_dat_o    (next_move),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_move_queue_dispatcher.sv
// Directed bench: instance A uses default sizing, instance B a 4-deep queue, 8-slot chunks
// and a 5-cycle settle gap.
module tb_move_queue_dispatcher;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic         a_rst, a_valid, a_ready, a_plan, a_start, a_done, a_busy, a_ovf, a_exec;
    logic [199:0] a_chunk;
    logic [3:0]   a_next;
    logic [8:0]   a_num, a_curr;

    logic         b_rst, b_valid, b_ready, b_plan, b_start, b_done, b_busy, b_ovf, b_exec;
    logic [31:0]  b_chunk;
    logic [3:0]   b_next;
    logic [2:0]   b_num, b_curr;

    int checks = 0;
    int errors = 0;
    int a_starts = 0;
    int b_starts = 0;

    move_queue_dispatcher #(
        .MOVE_W(4), .CHUNK_MOVES(50), .DEPTH(256), .GAP_CYCLES(0)
    ) u_a (
        .clock_25mhz(clk), .reset(a_rst), .chunk_in(a_chunk), .chunk_valid(a_valid),
        .chunk_ready(a_ready), .plan_done(a_plan), .next_move(a_next), .move_start(a_start),
        .move_done(a_done), .num_moves(a_num), .curr_step(a_curr), .busy(a_busy),
        .overflow(a_ovf), .exec_done(a_exec)
    );

    move_queue_dispatcher #(
        .MOVE_W(4), .CHUNK_MOVES(8), .DEPTH(4), .GAP_CYCLES(5)
    ) u_b (
        .clock_25mhz(clk), .reset(b_rst), .chunk_in(b_chunk), .chunk_valid(b_valid),
        .chunk_ready(b_ready), .plan_done(b_plan), .next_move(b_next), .move_start(b_start),
        .move_done(b_done), .num_moves(b_num), .curr_step(b_curr), .busy(b_busy),
        .overflow(b_ovf), .exec_done(b_exec)
    );

    always @(posedge clk) begin
        if (a_start) a_starts <= a_starts + 1;
        if (b_start) b_starts <= b_starts + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(input bit use_b, input string tag, input int budget, output int n);
        logic seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            seen = use_b ? b_start : a_start;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_ready(input bit use_b, input string tag, input int budget, output int n);
        logic seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            seen = use_b ? b_ready : a_ready;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic reset_a();
        a_rst = 1'b1;
        tick(1);
        a_rst = 1'b0;
        tick(1);
    endtask

    task automatic done_a();
        a_done = 1'b1;
        tick(1);
        a_done = 1'b0;
    endtask

    task automatic done_b();
        b_done = 1'b1;
        tick(1);
        b_done = 1'b0;
    endtask

    logic [3:0] t2_exp [3] = '{4'h2, 4'h4, 4'h6};
    logic [3:0] t3_exp [4] = '{4'h2, 4'h3, 4'h4, 4'h5};
    logic [3:0] t5_exp [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h5};

    initial begin
        int n;
        int snap;
        a_rst = 1'b1; b_rst = 1'b1;
        a_chunk = '0; a_valid = 1'b0; a_plan = 1'b0; a_done = 1'b0;
        b_chunk = '0; b_valid = 1'b0; b_plan = 1'b0; b_done = 1'b0;
        tick(2);
        check("rst_ready_during_reset", 32'(a_ready), 32'd0);
        a_rst = 1'b0; b_rst = 1'b0;
        tick(1);
        check("rst_ready_after", 32'(a_ready), 32'd1);
        check("rst_start", 32'(a_start), 32'd0);
        check("rst_next", 32'(a_next), 32'd0);
        check("rst_num", 32'(a_num), 32'd0);
        check("rst_curr", 32'(a_curr), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_ovf", 32'(a_ovf), 32'd0);
        check("rst_exec", 32'(a_exec), 32'd0);
        check("rst_b_num", 32'(b_num), 32'd0);

        // Two moves R, Ri through the default-sized block.
        a_chunk[7:0] = 8'h23;
        a_valid = 1'b1;
        tick(1);
        a_valid = 1'b0;
        check("t1_ready_low_scan", 32'(a_ready), 32'd0);
        wait_ready(1'b0, "t1_scan", 80, n);
        check("t1_scan_latency", 32'(n), 32'd50);
        check("t1_num", 32'(a_num), 32'd2);
        a_plan = 1'b1;
        tick(1);
        a_plan = 1'b0;
        wait_start(1'b0, "t1_first", 10, n);
        check("t1_plan_latency", 32'(n), 32'd2);
        check("t1_next0", 32'(a_next), 32'h2);
        check("t1_busy", 32'(a_busy), 32'd1);
        tick(1);
        check("t1_start_one_cycle", 32'(a_start), 32'd0);
        done_a();
        wait_start(1'b0, "t1_second", 10, n);
        check("t1_done_latency", 32'(n), 32'd1);
        check("t1_next1", 32'(a_next), 32'h3);
        check("t1_curr1", 32'(a_curr), 32'd1);
        done_a();
        tick(3);
        check("t1_curr_final", 32'(a_curr), 32'd2);
        check("t1_num_final", 32'(a_num), 32'd2);
        check("t1_exec", 32'(a_exec), 32'd1);
        check("t1_busy_final", 32'(a_busy), 32'd0);
        check("t1_next_held", 32'(a_next), 32'h3);

        // NOP filtering: 2,E,4,1,F,6 -> 2,4,6.
        reset_a();
        a_chunk = '0;
        a_chunk[23:0] = 24'h2E41F6;
        a_valid = 1'b1;
        tick(1);
        a_valid = 1'b0;
        wait_ready(1'b0, "t2_scan", 80, n);
        check("t2_num", 32'(a_num), 32'd3);
        a_plan = 1'b1;
        tick(1);
        a_plan = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_start(1'b0, "t2_start", 10, n);
            check("t2_move", 32'(a_next), 32'(t2_exp[i]));
            done_a();
        end
        tick(3);
        check("t2_curr", 32'(a_curr), 32'd3);
        check("t2_exec", 32'(a_exec), 32'd1);

        // Overflow and settle gap on the 4-deep instance.
        b_chunk = 32'h2345_6700;
        b_valid = 1'b1;
        tick(1);
        b_valid = 1'b0;
        wait_ready(1'b1, "t3_scan", 20, n);
        check("t3_scan_latency", 32'(n), 32'd8);
        check("t3_ovf", 32'(b_ovf), 32'd1);
        check("t3_num", 32'(b_num), 32'd4);
        b_plan = 1'b1;
        tick(1);
        b_plan = 1'b0;
        wait_start(1'b1, "t3_first", 10, n);
        check("t3_move0", 32'(b_next), 32'(t3_exp[0]));
        for (int i = 1; i < 4; i++) begin
            done_b();
            wait_start(1'b1, "t3_gap", 20, n);
            check("t3_gap_latency", 32'(n), 32'd6);
            check("t3_move", 32'(b_next), 32'(t3_exp[i]));
        end
        done_b();
        tick(10);
        check("t3_curr", 32'(b_curr), 32'd4);
        check("t3_exec", 32'(b_exec), 32'd1);
        check("t3_start_count", 32'(b_starts), 32'd4);
        done_b();
        tick(2);
        check("t3_done_in_wait_ignored", 32'(b_curr), 32'd4);
        check("t3_start_count_after", 32'(b_starts), 32'd4);

        // Back-to-back chunks, plan_done during second scan.
        reset_a();
        a_chunk = '0;
        a_chunk[11:0] = 12'hABC;
        a_valid = 1'b1;
        tick(1);
        a_chunk = '0;
        a_chunk[7:0] = 8'hD5;
        wait_ready(1'b0, "t5_scan1", 80, n);
        tick(1);
        a_valid = 1'b0;
        check("t5_second_accepted", 32'(a_ready), 32'd0);
        tick(5);
        a_plan = 1'b1;
        tick(1);
        a_plan = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_start(1'b0, "t5_start", 80, n);
            check("t5_move", 32'(a_next), 32'(t5_exp[i]));
            check("t5_exec_early", 32'(a_exec), 32'd0);
            done_a();
        end
        tick(3);
        check("t5_exec", 32'(a_exec), 32'd1);
        check("t5_curr", 32'(a_curr), 32'd5);
        check("t5_num", 32'(a_num), 32'd5);
        a_chunk = '0;
        a_chunk[3:0] = 4'h2;
        a_valid = 1'b1;
        tick(4);
        check("t5_third_ready", 32'(a_ready), 32'd0);
        check("t5_third_num", 32'(a_num), 32'd5);
        a_valid = 1'b0;

        // Reset while a move is in flight.
        reset_a();
        a_chunk = '0;
        a_chunk[7:0] = 8'h23;
        a_valid = 1'b1;
        tick(1);
        a_valid = 1'b0;
        wait_ready(1'b0, "t6_scan", 80, n);
        a_plan = 1'b1;
        tick(1);
        a_plan = 1'b0;
        wait_start(1'b0, "t6_start", 10, n);
        check("t6_busy_before", 32'(a_busy), 32'd1);
        a_rst = 1'b1;
        tick(1);
        a_rst = 1'b0;
        check("t6_busy", 32'(a_busy), 32'd0);
        check("t6_start", 32'(a_start), 32'd0);
        check("t6_next", 32'(a_next), 32'd0);
        check("t6_num", 32'(a_num), 32'd0);
        check("t6_curr", 32'(a_curr), 32'd0);
        check("t6_exec", 32'(a_exec), 32'd0);
        snap = a_starts;
        tick(20);
        check("t6_no_start", 32'(a_starts - snap), 32'd0);
        check("t6_ready", 32'(a_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
